// File: rtl/u_wb_fwd.sv
// Writeback buffer with operand forwarding: results travel through DEPTH
// stages before the regfile write; source operands are bypassed from pending writes.
module u_wb_fwd #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 3,
  parameter bit FWD_IN = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_we,
  input  logic [4:0]      ex_a,
  input  logic [XLEN-1:0] ex_d,
  input  logic [4:0]      rs1_a,
  input  logic [4:0]      rs2_a,
  input  logic [XLEN-1:0] rf_rs1_o,
  input  logic [XLEN-1:0] rf_rs2_o,
  output logic [XLEN-1:0] fwd_rs1,
  output logic [XLEN-1:0] fwd_rs2,
  output logic            fwd_hit1,
  output logic            fwd_hit2,
  output logic            rf_rd_e,
  output logic [4:0]      rf_rd_a,
  output logic [XLEN-1:0] rf_rd_i,
  output logic [3:0]      pend_cnt
);

  logic            st_we [DEPTH];
  logic [4:0]      st_a  [DEPTH];
  logic [XLEN-1:0] st_d  [DEPTH];

  logic cap_we;
  assign cap_we = ex_we & ~flush & (ex_a != 5'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        st_we[k] <= 1'b0;
        st_a[k]  <= '0;
        st_d[k]  <= '0;
      end
    end else if (!stall) begin
      st_we[0] <= cap_we;
      st_a[0]  <= cap_we ? ex_a : '0;
      st_d[0]  <= cap_we ? ex_d : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        st_we[k] <= st_we[k-1];
        st_a[k]  <= st_a[k-1];
        st_d[k]  <= st_d[k-1];
      end
    end
  end

  // Scan oldest to newest so that the newest matching write overrides older ones.
  function automatic logic [XLEN:0] lookup(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    logic            hit;
    logic [XLEN-1:0] val;
    hit = 1'b0;
    val = rf;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (st_we[k] && (st_a[k] == rs)) begin
        hit = 1'b1;
        val = st_d[k];
      end
    end
    if (FWD_IN && ex_we && !flush && (ex_a == rs)) begin
      hit = 1'b1;
      val = ex_d;
    end
    if (rs == 5'd0) begin
      hit = 1'b0;
      val = '0;
    end
    return {hit, val};
  endfunction

  always_comb begin
    {fwd_hit1, fwd_rs1} = lookup(rs1_a, rf_rs1_o);
    {fwd_hit2, fwd_rs2} = lookup(rs2_a, rf_rs2_o);
  end

  assign rf_rd_e = st_we[DEPTH-1] & ~stall;
  assign rf_rd_a = st_a[DEPTH-1];
  assign rf_rd_i = st_d[DEPTH-1];

  always_comb begin
    pend_cnt = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      pend_cnt = pend_cnt + 4'(st_we[k]);
    end
  end

endmodule

// File: tb/tb_u_wb_fwd.sv
// Self-checking bench for u_wb_fwd: directed scenarios plus randomized traffic
// against a queue-based model of pending register writes.
module tb_u_wb_fwd;
  localparam int XLEN = 32;
  localparam int D    = 3;

  logic            clk = 1'b0;
  logic            rstn, stall, flush, ex_we;
  logic [4:0]      ex_a, rs1_a, rs2_a;
  logic [XLEN-1:0] ex_d, rf_rs1_o, rf_rs2_o;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, rf_rd_i;
  logic            fwd_hit1, fwd_hit2, rf_rd_e;
  logic [4:0]      rf_rd_a;
  logic [3:0]      pend_cnt;

  int errors = 0;
  int checks = 0;

  u_wb_fwd #(.XLEN(XLEN), .DEPTH(D), .FWD_IN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .ex_we(ex_we), .ex_a(ex_a), .ex_d(ex_d),
    .rs1_a(rs1_a), .rs2_a(rs2_a), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .rf_rd_e(rf_rd_e), .rf_rd_a(rf_rd_a), .rf_rd_i(rf_rd_i), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  // Model: mq[0] is the newest pending write, mq[D-1] the one due at the regfile.
  typedef struct packed {
    logic            we;
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } ent_t;
  ent_t mq[$];

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < D; i++) mq.push_back('0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn && !stall) begin
      ent_t e;
      e.we = ex_we && !flush && (ex_a != 5'd0);
      e.a  = e.we ? ex_a : 5'd0;
      e.d  = e.we ? ex_d : '0;
      mq.push_front(e);
      void'(mq.pop_back());
    end
    #1;
  endtask

  function automatic void model_fwd(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                    output logic [XLEN-1:0] v, output logic h);
    v = rf;
    h = 1'b0;
    if (rs == 5'd0) begin
      v = '0;
      return;
    end
    if (ex_we && !flush && ex_a == rs) begin
      v = ex_d;
      h = 1'b1;
      return;
    end
    foreach (mq[i]) begin
      if (mq[i].we && mq[i].a == rs) begin
        v = mq[i].d;
        h = 1'b1;
        return;
      end
    end
  endfunction

  function automatic logic [3:0] model_pend();
    int n = 0;
    foreach (mq[i]) if (mq[i].we) n++;
    return 4'(n);
  endfunction

  task automatic idle();
    stall = 1'b0; flush = 1'b0; ex_we = 1'b0; ex_a = '0; ex_d = '0;
    rs1_a = '0; rs2_a = '0; rf_rs1_o = '0; rf_rs2_o = '0;
  endtask

  task automatic drain();
    idle();
    repeat (D) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    model_clear();
    #12;
    checks++;
    if ({rf_rd_e, rf_rd_a, rf_rd_i, pend_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: e=%0b a=%0d d=%h pend=%0d, required all zero",
               rf_rd_e, rf_rd_a, rf_rd_i, pend_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_latency();
    ex_we = 1'b1; ex_a = 5'd5; ex_d = 32'h11;
    tick();
    idle();
    for (int c = 1; c <= 4; c++) begin
      logic       e_exp = (c == 3);
      logic [3:0] p_exp = (c <= 3) ? 4'd1 : 4'd0;
      checks++;
      if (rf_rd_e !== e_exp || pend_cnt !== p_exp) begin
        errors++;
        $display("FAIL latency_c%0d: e=%0b pend=%0d, required e=%0b pend=%0d",
                 c, rf_rd_e, pend_cnt, e_exp, p_exp);
      end
      if (c == 3) begin
        checks++;
        if (rf_rd_a !== 5'd5 || rf_rd_i !== 32'h11) begin
          errors++;
          $display("FAIL latency_data: a=%0d d=%h, required a=5 d=11", rf_rd_a, rf_rd_i);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    drain();
    ex_we = 1'b1; ex_a = 5'd7; ex_d = 32'hA;
    tick();
    ex_d = 32'hB;
    tick();
    idle();
    rs1_a = 5'd7; rf_rs1_o = 32'hDEAD;
    #1;
    checks++;
    if (fwd_rs1 !== 32'hB || fwd_hit1 !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: rs1=%h hit=%0b, required rs1=b hit=1", fwd_rs1, fwd_hit1);
    end
    // Same register pending in the buffer and arriving from execute: execute wins.
    ex_we = 1'b1; ex_a = 5'd7; ex_d = 32'hC;
    #1;
    checks++;
    if (fwd_rs1 !== 32'hC || fwd_hit1 !== 1'b1) begin
      errors++;
      $display("FAIL ex_bypass: rs1=%h hit=%0b, required rs1=c hit=1", fwd_rs1, fwd_hit1);
    end
    idle();
    tick();
  endtask

  task automatic test_x0();
    drain();
    ex_we = 1'b1; ex_a = 5'd0; ex_d = 32'hFF; rs1_a = 5'd0; rf_rs1_o = 32'h55;
    #1;
    checks++;
    if (fwd_rs1 !== '0 || fwd_hit1 !== 1'b0) begin
      errors++;
      $display("FAIL x0_fwd: rs1=%h hit=%0b, required rs1=0 hit=0", fwd_rs1, fwd_hit1);
    end
    tick();
    idle();
    for (int c = 1; c <= D + 1; c++) begin
      checks++;
      if (pend_cnt !== 4'd0 || rf_rd_e !== 1'b0) begin
        errors++;
        $display("FAIL x0_capture_c%0d: pend=%0d e=%0b, required pend=0 e=0", c, pend_cnt, rf_rd_e);
      end
      tick();
    end
  endtask

  task automatic test_flush_stall();
    drain();
    flush = 1'b1; ex_we = 1'b1; ex_a = 5'd3; ex_d = 32'h33;
    tick();
    idle();
    checks++;
    if (pend_cnt !== 4'd0) begin
      errors++;
      $display("FAIL flush_capture: pend=%0d, required 0", pend_cnt);
    end
    ex_we = 1'b1; ex_a = 5'd1; ex_d = 32'h101;
    tick();
    ex_a = 5'd2; ex_d = 32'h202;
    tick();
    idle();
    tick();
    stall = 1'b1;
    ex_we = 1'b1; ex_a = 5'd9; ex_d = 32'h999;
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++;
      if (rf_rd_e !== 1'b0 || pend_cnt !== 4'd2) begin
        errors++;
        $display("FAIL stall_hold_c%0d: e=%0b pend=%0d, required e=0 pend=2", c, rf_rd_e, pend_cnt);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (rf_rd_e !== 1'b1 || rf_rd_a !== 5'd1 || rf_rd_i !== 32'h101) begin
      errors++;
      $display("FAIL stall_resume1: e=%0b a=%0d d=%h, required e=1 a=1 d=101", rf_rd_e, rf_rd_a, rf_rd_i);
    end
    tick();
    checks++;
    if (rf_rd_e !== 1'b1 || rf_rd_a !== 5'd2 || rf_rd_i !== 32'h202) begin
      errors++;
      $display("FAIL stall_resume2: e=%0b a=%0d d=%h, required e=1 a=2 d=202", rf_rd_e, rf_rd_a, rf_rd_i);
    end
    tick();
    checks++;
    if (rf_rd_e !== 1'b0 || pend_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stall_after: e=%0b pend=%0d, required e=0 pend=0", rf_rd_e, pend_cnt);
    end
  endtask

  task automatic test_no_match();
    drain();
    ex_we = 1'b1; ex_a = 5'd4; ex_d = 32'h44;
    tick();
    idle();
    rs2_a = 5'd9; rf_rs2_o = 32'h1234;
    #1;
    checks++;
    if (fwd_rs2 !== 32'h1234 || fwd_hit2 !== 1'b0) begin
      errors++;
      $display("FAIL no_match: rs2=%h hit=%0b, required rs2=1234 hit=0", fwd_rs2, fwd_hit2);
    end
  endtask

  task automatic test_oldest_fwd();
    drain();
    ex_we = 1'b1; ex_a = 5'd6; ex_d = 32'h66;
    tick();
    idle();
    tick();
    tick();
    rs2_a = 5'd6; rf_rs2_o = 32'h0BAD;
    #1;
    checks++;
    if (rf_rd_e !== 1'b1 || fwd_rs2 !== 32'h66 || fwd_hit2 !== 1'b1) begin
      errors++;
      $display("FAIL oldest_fwd: e=%0b rs2=%h hit=%0b, required e=1 rs2=66 hit=1",
               rf_rd_e, fwd_rs2, fwd_hit2);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid();
    drain();
    for (int i = 1; i <= 3; i++) begin
      ex_we = 1'b1; ex_a = 5'(10 + i); ex_d = 32'(i);
      tick();
    end
    idle();
    checks++;
    if (pend_cnt !== 4'd3) begin
      errors++;
      $display("FAIL mid_pending: pend=%0d, required 3", pend_cnt);
    end
    #2;
    rstn = 1'b0;
    model_clear();
    #1;
    checks++;
    if ({rf_rd_e, rf_rd_a, rf_rd_i, pend_cnt} !== '0) begin
      errors++;
      $display("FAIL mid_reset: e=%0b a=%0d d=%h pend=%0d, required all zero",
               rf_rd_e, rf_rd_a, rf_rd_i, pend_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 1; c <= D + 1; c++) begin
      tick();
      checks++;
      if (rf_rd_e !== 1'b0 || pend_cnt !== 4'd0) begin
        errors++;
        $display("FAIL mid_release_c%0d: e=%0b pend=%0d, required e=0 pend=0", c, rf_rd_e, pend_cnt);
      end
    end
  endtask

  task automatic test_random();
    drain();
    for (int c = 0; c < 400; c++) begin
      logic [XLEN-1:0] v1, v2;
      logic            h1, h2, e_exp;
      stall    = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      ex_we    = $urandom_range(0, 1);
      ex_a     = 5'($urandom_range(0, 7));
      ex_d     = $urandom;
      rs1_a    = 5'($urandom_range(0, 7));
      rs2_a    = 5'($urandom_range(0, 7));
      rf_rs1_o = $urandom;
      rf_rs2_o = $urandom;
      #1;
      model_fwd(rs1_a, rf_rs1_o, v1, h1);
      model_fwd(rs2_a, rf_rs2_o, v2, h2);
      e_exp = mq[D-1].we && !stall;
      checks++;
      if ({fwd_rs1, fwd_hit1, fwd_rs2, fwd_hit2, rf_rd_e, rf_rd_a, rf_rd_i, pend_cnt} !==
          {v1, h1, v2, h2, e_exp, mq[D-1].a, mq[D-1].d, model_pend()}) begin
        errors++;
        $display("FAIL random_c%0d: rs1=%h/%0b rs2=%h/%0b wr=%0b/%0d/%h pend=%0d, required rs1=%h/%0b rs2=%h/%0b wr=%0b/%0d/%h pend=%0d",
                 c, fwd_rs1, fwd_hit1, fwd_rs2, fwd_hit2, rf_rd_e, rf_rd_a, rf_rd_i, pend_cnt,
                 v1, h1, v2, h2, e_exp, mq[D-1].a, mq[D-1].d, model_pend());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_x0();
    test_flush_stall();
    test_no_match();
    test_oldest_fwd();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/u_wb_fwd.md
U_WB_FWD -- requirements
Module: u_wb_fwd

Interface
REQ-001 Parameter XLEN, default 32, data width of every register value.
REQ-002 Parameter DEPTH, default 3, range 1..8, number of writeback buffer stages.
REQ-003 Parameter FWD_IN, default 1, enables forwarding of the current-cycle execute result.
REQ-004 clk  in  1  single clock, all state updates on its rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 stall  in  1  holds all buffer stages; no regfile write issued.
REQ-007 flush  in  1  kills the current execute result (not captured).
REQ-008 ex_we  in  1  execute result writes a destination register.
REQ-009 ex_a  in  5  execute destination register address.
REQ-010 ex_d  in  XLEN  execute result data.
REQ-011 rs1_a, rs2_a  in  5 each  source addresses of the instruction entering execute.
REQ-012 rf_rs1_o, rf_rs2_o  in  XLEN each  regfile read data for rs1_a/rs2_a.
REQ-013 fwd_rs1, fwd_rs2  out  XLEN each  forwarded operand values.
REQ-014 fwd_hit1, fwd_hit2  out  1 each  operand was taken from a pending write, not the regfile.
REQ-015 rf_rd_e, rf_rd_a, rf_rd_i  out  1/5/XLEN  regfile write port.
REQ-016 pend_cnt  out  4  number of valid buffer stages.

Function
REQ-017 Buffer is DEPTH stages buf[0..DEPTH-1], each {we, a, d}; buf[0] newest.
REQ-018 Capture (stall=0): buf[0] <= {ex_we & ~flush & (ex_a!=0), masked a, masked d}; masked a/d = 0 when captured we=0.
REQ-019 Advance (stall=0): buf[k] <= buf[k-1] for k=1..DEPTH-1, every cycle; latency ex_* to rf_rd_* = DEPTH cycles with no stalls.
REQ-020 stall=1: every stage holds, ex_* ignored; stall has priority over flush.
REQ-021 rf_rd_e = buf[DEPTH-1].we & ~stall; rf_rd_a/rf_rd_i = buf[DEPTH-1].a/.d combinationally; each entry written exactly once.
REQ-022 Forward search for rsN_a, priority newest first: ex_* (only if FWD_IN=1, ex_we=1, flush=0), then buf[0], ..., buf[DEPTH-1]; first match with we=1 and a==rsN_a wins.
REQ-023 rsN_a==0: fwd_rsN=0, fwd_hitN=0, regardless of buffer contents.
REQ-024 No match: fwd_rsN=rf_rsN_o, fwd_hitN=0.
REQ-025 buf[DEPTH-1] match forwards even when rf_rd_e=1 the same cycle (regfile write-after-read).
REQ-026 pend_cnt = count of buf[k].we=1, combinational, 0..DEPTH.
REQ-027 Forwarding paths combinational, no added cycle; all state only in buf[].

Reset
REQ-028 rstn=0 asynchronously clears every buf[k] to {0,0,0}; rf_rd_e=0, rf_rd_a=0, rf_rd_i=0, pend_cnt=0.
REQ-029 Reset mid-operation discards all pending writes; no regfile write follows release.
REQ-030 First capture occurs on the first rising clk after rstn deasserts.

Verification (DEPTH=3, FWD_IN=1)
REQ-031 ex_we=1, ex_a=5, ex_d=0x11 one cycle -> rf_rd_e=1, a=5, d=0x11 exactly 3 cycles later for one cycle; pend_cnt 1,1,1 then 0.
REQ-032 Back-to-back writes x7=0xA then x7=0xB, rs1_a=7 next cycle -> fwd_rs1=0xB, fwd_hit1=1 (newest wins).
REQ-033 ex_we=1, ex_a=0, ex_d=0xFF; rs1_a=0 -> nothing captured, pend_cnt=0, fwd_rs1=0, no regfile write.
REQ-034 flush=1 with ex_we=1, ex_a=3 -> no capture; stall=1 for 2 cycles with 2 pending -> rf_rd_e=0 during stall, writes resume in order after.
REQ-035 rs2_a=9 with no pending x9, rf_rs2_o=0x1234 -> fwd_rs2=0x1234, fwd_hit2=0.
REQ-036 rstn pulsed low with 3 pending entries -> outputs 0 immediately, no rf_rd_e afterwards.
